channel_row_mapper: RTL and testbench
=====================================

# channel_row_mapper

Registered, divider-free successor to the combinational row-to-channel mapper. It splits the active display rows evenly among the enabled scope channels and keeps that split constant for the whole frame. Once per frame, during vertical blanking, it latches `channel_enable`, counts the enabled channels and computes the per-channel height with a serial divider. During the visible region it tracks the current channel incrementally, row by row, and adds optional inter-channel gap rows plus a row-within-channel output for waveform scaling.

## Interface
- `MAX_CHAN_COUNT`, 10, number of channel enable bits.
- `VER_RES`, `VGA_VER_RES` from vga.h (480), visible rows per frame.
- `OFFSET`, 0, rows at the top reserved for the header; these rows are never channel rows.
- `GAP`, 0, blank separator rows at the bottom of each channel slot.
- Derived widths: RW = $clog2(VER_RES); CW = $clog2(MAX_CHAN_COUNT); NW = $clog2(MAX_CHAN_COUNT+1). NW is the count width and holds MAX_CHAN_COUNT itself.
- `clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `channel_enable`  in  MAX_CHAN_COUNT  channel enables; sampled only on `frame_start`.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blanking.
- `row_valid`  in  1  one-cycle pulse at the start of each visible row.
- `pixel_row`  in  RW  index of the row flagged by `row_valid`; 0..VER_RES-1, increments by 1.
- `ready`  out  1  frame geometry valid.
- `is_channel`  out  1  current row is drawn as part of a channel.
- `is_gap`  out  1  current row is a separator row.
- `channel_number`  out  CW  physical channel index of the current row.
- `row_in_channel`  out  RW  row offset within the current channel slot.
- `channel_height`  out  RW  slot height for this frame: (VER_RES-OFFSET)/count.

## Operation
- **FSM states:** IDLE, COUNT, DIVIDE, READY.
- **Frame start:** a `frame_start` pulse in any state latches `channel_enable` into `en_q` and enters COUNT.
- **COUNT (1 cycle):** `cnt` = popcount(`en_q`), NW bits.
  - If `cnt`==0: `channel_height`=0 and the FSM goes directly to READY.
  - Otherwise the FSM enters DIVIDE.
- **DIVIDE (RW cycles):** restoring divider, one quotient bit per cycle, computes (VER_RES-OFFSET)/`cnt`. The remainder is discarded, so the bottom rows left over are neither channel nor gap rows. The FSM then enters READY.
- **Effective gap:** `gap_eff` = GAP if `channel_height` > 2*GAP, else 0.
- **Row tracking (READY only).** Each `row_valid` updates the tracking registers:
  - `pixel_row` < OFFSET: all row outputs are 0.
  - `pixel_row` == OFFSET: `vis`=0, `row_in_channel`=0, `ptr` = lowest set bit of `en_q`.
  - `pixel_row` > OFFSET:
    - if `row_in_channel` == `channel_height`-1: wrap `row_in_channel` to 0, `vis`+1, `ptr` = lowest set bit of `en_q` above `ptr` (priority search).
    - otherwise `row_in_channel`+1.
  - `channel_number` = `ptr`.
  - `is_channel` = (`pixel_row` >= OFFSET) & (`cnt` != 0) & (`vis` < `cnt`) & (`row_in_channel` < `channel_height`-`gap_eff`).
  - `is_gap` = the same conditions, but with `row_in_channel` >= `channel_height`-`gap_eff`.
  - Once `vis` >= `cnt` (remainder rows): `is_channel`=0, `is_gap`=0, and `channel_number` holds its last value.
- **`row_valid` while not READY:** ignored; row outputs stay 0.
- **Changes to `channel_enable` outside `frame_start`:** ignored until the next `frame_start`.
- **`frame_start` during DIVIDE or mid-frame:** aborts the current operation, clears `ready` and the row outputs, and restarts at COUNT with the new enables.
- **Simultaneous `frame_start` and `row_valid`:** `frame_start` wins; the row is ignored.

## Timing
- **Reset:** while `rst_n`=0 at a clock edge, state←IDLE and all outputs←0, including `ready`, `channel_height`, `channel_number` and `row_in_channel`. Reset mid-DIVIDE discards the partial quotient.
- **Geometry latency:** with `frame_start` sampled at edge 0, COUNT occupies cycle 1 and DIVIDE occupies cycles 2..RW+1. `ready`=1 and `channel_height` are valid from edge RW+2 (11 cycles for VER_RES=480) until the next `frame_start`. If `cnt`==0, `ready`=1 at edge 2.
- **System constraint:** vertical blanking must be at least RW+2 cycles long.
- **Row outputs:** registered; they reflect the row sampled by `row_valid` one cycle later and are held until the next `row_valid`.
- **Throughput:** `row_valid` may arrive every cycle.

## Test plan
- **Even split:** VER_RES=480, OFFSET=0, GAP=0, enable=`b100101`.
  - Required: `ready` 11 cycles after `frame_start`; `channel_height`=160.
  - Rows 0/159/160/320/479 give `channel_number` 0/0/2/5/5 with `row_in_channel` 0/159/0/0/159; `is_channel`=1 throughout.
- **Remainder and offset:** OFFSET=32, all 10 channels enabled.
  - `channel_height`=44; rows 0..31 have `is_channel`=0.
  - Row 32 gives channel 0; row 471 gives channel 9 with `row_in_channel` 43.
  - Rows 472..479 have `is_channel`=0 and `is_gap`=0.
- **Gap:** GAP=2, enable=`b0011`.
  - `channel_height`=240; rows 238 and 239 have `is_gap`=1 and `is_channel`=0.
  - Row 240 gives channel 1 with `is_channel`=1.
  - With 10 channels enabled and GAP=30 (height 48 ≤ 60), `gap_eff`=0 and `is_gap` is never set.
- **Zero channels:** enable=0.
  - `ready` at edge 2; `channel_height`=0; `is_channel`=0 and `is_gap`=0 on every row.
- **Mid-frame changes:**
  - Toggling `channel_enable` at row 200 has no effect on the mapping.
  - A `frame_start` at row 300 drops `ready` at the next edge; outputs stay 0 until the recompute completes, which then uses the new enables.
- **Reset and collisions:**
  - `rst_n`=0 for one cycle during DIVIDE: all outputs are 0 at the next edge, and no `ready` appears until a new `frame_start`.
  - `frame_start` and `row_valid` asserted in the same cycle: the row is ignored.

Source files
------------

// File: rtl/channel_row_mapper.sv
// Registered row-to-channel mapper: latches enables per frame, serially divides the visible
// height among enabled channels, then tracks the current channel row by row.
module channel_row_mapper #(
    parameter int unsigned MAX_CHAN_COUNT = 10,
    parameter int unsigned VER_RES        = 480,
    parameter int unsigned OFFSET         = 0,
    parameter int unsigned GAP            = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [MAX_CHAN_COUNT-1:0]         channel_enable,
    input  logic                              frame_start,
    input  logic                              row_valid,
    input  logic [$clog2(VER_RES)-1:0]        pixel_row,
    output logic                              ready,
    output logic                              is_channel,
    output logic                              is_gap,
    output logic [$clog2(MAX_CHAN_COUNT)-1:0] channel_number,
    output logic [$clog2(VER_RES)-1:0]        row_in_channel,
    output logic [$clog2(VER_RES)-1:0]        channel_height
);
    localparam int unsigned RW = $clog2(VER_RES);
    localparam int unsigned CW = $clog2(MAX_CHAN_COUNT);
    localparam int unsigned NW = $clog2(MAX_CHAN_COUNT + 1);
    localparam int unsigned SW = $clog2(RW);

    localparam logic [RW-1:0] Dividend = RW'(VER_RES - OFFSET);
    localparam logic [RW-1:0] GapRows  = RW'(GAP);
    localparam logic [RW:0]   GapTwice = (RW+1)'(2 * GAP);

    typedef enum logic [1:0] {StIdle, StCount, StDivide, StReady} state_e;

    state_e                    state_q, state_d;
    logic [MAX_CHAN_COUNT-1:0] en_q;
    logic [NW-1:0]             cnt_q, cnt_pop;
    logic [RW-1:0]             height_q;
    logic                      ready_q;
    logic [NW-1:0]             rem_q, rem_nx;
    logic [RW-2:0]             quo_q;
    logic [RW-1:0]             quo_nx;
    logic [SW-1:0]             step_q;
    logic [NW:0]               trial, diff;
    logic                      q_bit;

    logic [NW-1:0] vis_q, vis_nx;
    logic [RW-1:0] rin_q, rin_nx;
    logic [CW-1:0] ptr_q, ptr_nx, low_bit, next_bit;
    logic          is_channel_q, is_gap_q, is_channel_nx, is_gap_nx;
    logic [RW:0]   row_rel;
    logic [RW-1:0] gap_eff, body_rows;
    logic          in_use;

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = StCount;
        end else begin
            unique case (state_q)
                StCount:  state_d = (cnt_pop == '0) ? StReady : StDivide;
                StDivide: if (step_q == '0) state_d = StReady;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_pop  = '0;
        low_bit  = '0;
        next_bit = ptr_q;
        for (int i = 0; i < MAX_CHAN_COUNT; i++) cnt_pop = cnt_pop + NW'(en_q[i]);
        // Descending scan so the lowest qualifying bit is the last one written.
        for (int i = MAX_CHAN_COUNT - 1; i >= 0; i--) begin
            if (en_q[i]) low_bit = CW'(i);
            if (en_q[i] && (CW'(i) > ptr_q)) next_bit = CW'(i);
        end

        trial  = {rem_q, Dividend[step_q]};
        diff   = trial - {1'b0, cnt_q};
        q_bit  = trial >= {1'b0, cnt_q};
        rem_nx = q_bit ? diff[NW-1:0] : trial[NW-1:0];
        quo_nx = {quo_q, q_bit};
    end

    always_comb begin
        vis_nx    = vis_q;
        rin_nx    = rin_q;
        ptr_nx    = ptr_q;
        row_rel   = {1'b0, pixel_row} - (RW+1)'(OFFSET);
        gap_eff   = ({1'b0, height_q} > GapTwice) ? GapRows : '0;
        body_rows = height_q - gap_eff;
        if (row_rel[RW]) begin
            rin_nx = '0;
            ptr_nx = '0;
        end else if (row_rel == '0) begin
            vis_nx = '0;
            rin_nx = '0;
            ptr_nx = low_bit;
        end else if (rin_q == height_q - 1'b1) begin
            rin_nx = '0;
            ptr_nx = next_bit;
            if (vis_q != '1) vis_nx = vis_q + 1'b1;
        end else begin
            rin_nx = rin_q + 1'b1;
        end
        in_use        = !row_rel[RW] && (cnt_q != '0) && (vis_nx < cnt_q);
        is_channel_nx = in_use && (rin_nx < body_rows);
        is_gap_nx     = in_use && (rin_nx >= body_rows);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            en_q         <= '0;
            cnt_q        <= '0;
            height_q     <= '0;
            ready_q      <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            vis_q        <= '0;
            rin_q        <= '0;
            ptr_q        <= '0;
            is_channel_q <= 1'b0;
            is_gap_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q == StReady) && !frame_start;
            if (frame_start) begin
                en_q         <= channel_enable;
                height_q     <= '0;
                vis_q        <= '0;
                rin_q        <= '0;
                ptr_q        <= '0;
                is_channel_q <= 1'b0;
                is_gap_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    StCount: begin
                        cnt_q    <= cnt_pop;
                        height_q <= '0;
                        rem_q    <= '0;
                        quo_q    <= '0;
                        step_q   <= SW'(RW - 1);
                    end
                    StDivide: begin
                        rem_q  <= rem_nx;
                        quo_q  <= quo_nx[RW-2:0];
                        step_q <= step_q - 1'b1;
                        if (step_q == '0) height_q <= quo_nx;
                    end
                    StReady: begin
                        if (ready_q && row_valid) begin
                            vis_q        <= vis_nx;
                            rin_q        <= rin_nx;
                            ptr_q        <= ptr_nx;
                            is_channel_q <= is_channel_nx;
                            is_gap_q     <= is_gap_nx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ready          = ready_q;
    assign is_channel     = is_channel_q;
    assign is_gap         = is_gap_q;
    assign channel_number = ptr_q;
    assign row_in_channel = rin_q;
    assign channel_height = height_q;

endmodule

// File: tb/tb_channel_row_mapper.sv
// Four mapper instances (different OFFSET/GAP) share stimulus; a queue-based scoreboard
// checks every processed row against a division-based reference.
module tb_channel_row_mapper;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] channel_enable = '0;
    logic       frame_start = 1'b0;
    logic       row_valid = 1'b0;
    logic [8:0] pixel_row = '0;

    logic       rdy[4];
    logic       isc[4];
    logic       isg[4];
    logic [3:0] num[4];
    logic [8:0] rin[4];
    logic [8:0] hgt[4];

    int offs[4] = '{0, 32, 0, 0};
    int gaps[4] = '{0, 0, 2, 30};

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       chk_map;
        logic       is_ch;
        logic       is_gp;
        logic [3:0] num;
        logic [8:0] rin;
    } exp_t;
    typedef exp_t [3:0] exp4_t;

    exp4_t      sbq[$];
    logic [9:0] cur_en = '0;
    logic       rv_s = 1'b0;

    always #5 clk = ~clk;

    channel_row_mapper #(.OFFSET(0), .GAP(0)) u_a (
        .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .frame_start(frame_start),
        .row_valid(row_valid), .pixel_row(pixel_row), .ready(rdy[0]), .is_channel(isc[0]),
        .is_gap(isg[0]), .channel_number(num[0]), .row_in_channel(rin[0]),
        .channel_height(hgt[0]));
    channel_row_mapper #(.OFFSET(32), .GAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .frame_start(frame_start),
        .row_valid(row_valid), .pixel_row(pixel_row), .ready(rdy[1]), .is_channel(isc[1]),
        .is_gap(isg[1]), .channel_number(num[1]), .row_in_channel(rin[1]),
        .channel_height(hgt[1]));
    channel_row_mapper #(.OFFSET(0), .GAP(2)) u_c (
        .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .frame_start(frame_start),
        .row_valid(row_valid), .pixel_row(pixel_row), .ready(rdy[2]), .is_channel(isc[2]),
        .is_gap(isg[2]), .channel_number(num[2]), .row_in_channel(rin[2]),
        .channel_height(hgt[2]));
    channel_row_mapper #(.OFFSET(0), .GAP(30)) u_d (
        .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .frame_start(frame_start),
        .row_valid(row_valid), .pixel_row(pixel_row), .ready(rdy[3]), .is_channel(isc[3]),
        .is_gap(isg[3]), .channel_number(num[3]), .row_in_channel(rin[3]),
        .channel_height(hgt[3]));

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d want %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int d, input logic [9:0] en, input int r,
                                   input bit ok);
        exp_t e;
        int cnt, h, ge, k, rr, seen;
        e = '0;
        e.chk_map = 1'b1;
        if (!ok || r < offs[d]) return e;
        cnt = $countones(en);
        if (cnt == 0) begin
            e.chk_map = 1'b0;
            return e;
        end
        h  = (480 - offs[d]) / cnt;
        ge = (h > 2 * gaps[d]) ? gaps[d] : 0;
        k  = (r - offs[d]) / h;
        rr = (r - offs[d]) % h;
        e.rin = 9'(rr);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (en[i]) begin
                if (seen <= k) e.num = 4'(i);
                seen++;
            end
        end
        if (k < cnt) begin
            e.is_ch = (rr < h - ge);
            e.is_gp = !e.is_ch;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input int r, input bit ok);
        exp4_t s;
        for (int d = 0; d < 4; d++) s[d] = model(d, cur_en, r, ok);
        sbq.push_back(s);
        pixel_row = 9'(r);
        row_valid = 1'b1;
    endtask

    task automatic run_rows(input int first, input int last, input bit ok);
        for (int r = first; r <= last; r++) begin
            push_row(r, ok);
            tick();
        end
        row_valid = 1'b0;
    endtask

    // coll: a row collides with frame_start; busy: rows arrive while geometry is recomputed.
    task automatic start_frame(input logic [9:0] en, input int lat, input int h0, input int h1,
                               input int h2, input int h3, input bit coll, input bit busy);
        int hx[4];
        hx = '{h0, h1, h2, h3};
        if (coll) push_row(5, 1'b0);
        frame_start    = 1'b1;
        channel_enable = en;
        cur_en         = en;
        tick();
        frame_start = 1'b0;
        row_valid   = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) tick();
            row_valid = 1'b0;
            for (int d = 0; d < 4; d++) begin
                if (c < lat) chk("ready_low", d, int'(rdy[d]), 0);
                else begin
                    chk("ready_high", d, int'(rdy[d]), 1);
                    chk("height", d, int'(hgt[d]), hx[d]);
                end
            end
            if (busy && c <= lat - 2) push_row(301 + c, 1'b0);
        end
        row_valid = 1'b0;
    endtask

    always @(posedge clk) rv_s <= row_valid;

    always @(negedge clk) begin
        if (rv_s) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 0, 1, 0);
            end else begin
                exp4_t s;
                s = sbq.pop_front();
                for (int d = 0; d < 4; d++) begin
                    chk("is_channel", d, int'(isc[d]), int'(s[d].is_ch));
                    chk("is_gap", d, int'(isg[d]), int'(s[d].is_gp));
                    if (s[d].chk_map) begin
                        chk("channel_number", d, int'(num[d]), int'(s[d].num));
                        chk("row_in_channel", d, int'(rin[d]), int'(s[d].rin));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 4; d++) begin
            chk("rst_ready", d, int'(rdy[d]), 0);
            chk("rst_height", d, int'(hgt[d]), 0);
            chk("rst_number", d, int'(num[d]), 0);
        end
        rst_n = 1'b1;
        tick();

        // Even split; enables change mid-frame without effect.
        start_frame(10'b0000100101, 11, 160, 149, 160, 160, 1'b0, 1'b0);
        run_rows(0, 199, 1'b1);
        channel_enable = 10'b1111011010;
        run_rows(200, 479, 1'b1);

        // All channels (remainder rows, gap suppression) with a colliding row.
        start_frame(10'h3FF, 11, 48, 44, 48, 48, 1'b1, 1'b0);
        run_rows(0, 479, 1'b1);

        start_frame(10'b0000000011, 11, 240, 224, 240, 240, 1'b0, 1'b0);
        run_rows(0, 479, 1'b1);

        start_frame(10'b0000000000, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        run_rows(0, 479, 1'b1);

        // Restart mid-frame with new enables.
        start_frame(10'b1000000001, 11, 240, 224, 240, 240, 1'b0, 1'b0);
        run_rows(0, 299, 1'b1);
        start_frame(10'b0000011110, 11, 120, 112, 120, 120, 1'b0, 1'b1);
        run_rows(0, 479, 1'b1);

        // Reset during DIVIDE.
        frame_start    = 1'b1;
        channel_enable = 10'b0000100101;
        cur_en         = channel_enable;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_div_ready", d, int'(rdy[d]), 0);
            chk("rst_div_height", d, int'(hgt[d]), 0);
            chk("rst_div_row", d, int'(rin[d]), 0);
        end
        repeat (15) tick();
        for (int d = 0; d < 4; d++) chk("no_ready_after_rst", d, int'(rdy[d]), 0);
        run_rows(0, 9, 1'b0);

        start_frame(10'b0000100101, 11, 160, 149, 160, 160, 1'b0, 1'b0);
        run_rows(0, 479, 1'b1);

        repeat (3) tick();
        chk("sb_drained", 0, sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
